// File: rtl/tl_inflight_monitor.sv
// tl_inflight_monitor: passive TileLink A/D protocol monitor.
// Tracks per-source outstanding requests, multi-beat burst stability and
// (optionally) response latency, and reports violations as a registered
// error code/source pulse plus sticky per-code flags.
// Optional feature macro: TL_MONITOR_TIMEOUT_EN enables the per-source
// timeout counters and error code 7; without it err_flags[7] stays 0.
module tl_inflight_monitor #(
  parameter int SOURCE_BITS    = 3,
  parameter int ADDR_BITS      = 31,
  parameter int SIZE_BITS      = 3,
  parameter int BEAT_LOG2      = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   a_valid,
  input  logic                   a_ready,
  input  logic [2:0]             a_opcode,
  input  logic [SIZE_BITS-1:0]   a_size,
  input  logic [SOURCE_BITS-1:0] a_source,
  input  logic [ADDR_BITS-1:0]   a_address,
  input  logic                   d_valid,
  input  logic                   d_ready,
  input  logic [2:0]             d_opcode,
  input  logic [SIZE_BITS-1:0]   d_size,
  input  logic [SOURCE_BITS-1:0] d_source,
  output logic                   err_valid,
  output logic [3:0]             err_code,
  output logic [SOURCE_BITS-1:0] err_source,
  output logic [9:0]             err_flags,
  output logic [SOURCE_BITS:0]   inflight_count
);

  localparam int NSRC   = 1 << SOURCE_BITS;
  // Wide enough for the largest burst length 1 << (2^SIZE_BITS-1-BEAT_LOG2).
  localparam int BCNT_W = 1 << SIZE_BITS;

  genvar gi;

  // Number of data beats carried by a message of the given log2 size.
  function automatic logic [BCNT_W-1:0] beats_of(input logic [SIZE_BITS-1:0] size);
    int sz;
    sz = int'(size);
    if (sz <= BEAT_LOG2) return BCNT_W'(1);
    return BCNT_W'(1) << (sz - BEAT_LOG2);
  endfunction

  // Burst trackers: remaining beats after the current one plus first-beat fields.
  logic [BCNT_W-1:0]      a_rem_reg, d_rem_reg;
  logic [2:0]             a_op_reg, d_op_reg;
  logic [SIZE_BITS-1:0]   a_size_reg, d_size_reg;
  logic [SOURCE_BITS-1:0] a_src_reg, d_src_reg;
  logic [ADDR_BITS-1:0]   a_addr_reg;
  logic                   d_req_ok_reg;   // D burst started on a busy source

  // Per-source table.
  logic [NSRC-1:0]        busy_reg;
  logic [NSRC-1:0]        exp_op_reg;     // expected D opcode (AccessAck=0 / AccessAckData=1)
  logic [SIZE_BITS-1:0]   lsize_reg [NSRC];

  // Reporting registers.
  logic                   err_valid_reg;
  logic [3:0]             err_code_reg;
  logic [SOURCE_BITS-1:0] err_source_reg;
  logic [9:0]             err_flags_reg;
  logic [SOURCE_BITS:0]   inflight_reg;

  logic                   a_fire, d_fire, a_first, a_mid, d_first, d_mid, d_last;
  logic [BCNT_W-1:0]      a_beats, d_beats;
  logic [SOURCE_BITS-1:0] ret_src;
  logic                   ret_ok, retire;
  logic [ADDR_BITS-1:0]   align_mask;
  logic [NSRC-1:0]        arm_vec, ret_vec, busy_next;
  logic [9:0]             viol;
  logic [3:0]             code_next;
  logic [SOURCE_BITS-1:0] src_next;
  logic [SOURCE_BITS:0]   count_next;
  logic                   tout_any;
  logic [SOURCE_BITS-1:0] tout_src;

  assign a_fire  = a_valid & a_ready;
  assign d_fire  = d_valid & d_ready;
  assign a_first = a_fire & (a_rem_reg == '0);
  assign a_mid   = a_fire & (a_rem_reg != '0);
  assign d_first = d_fire & (d_rem_reg == '0);
  assign d_mid   = d_fire & (d_rem_reg != '0);

  // Only Put requests and AccessAckData responses carry multi-beat data.
  assign a_beats = ((a_opcode == 3'd0) || (a_opcode == 3'd1)) ? beats_of(a_size) : BCNT_W'(1);
  assign d_beats = (d_opcode == 3'd1) ? beats_of(d_size) : BCNT_W'(1);
  assign d_last  = (d_first & (d_beats == BCNT_W'(1))) | (d_mid & (d_rem_reg == BCNT_W'(1)));

  // A burst that began on an idle source never touches the table.
  assign ret_src = d_first ? d_source : d_src_reg;
  assign ret_ok  = d_first ? busy_reg[d_source] : d_req_ok_reg;
  assign retire  = d_last & ret_ok;

  assign align_mask = (ADDR_BITS'(1) << a_size) - ADDR_BITS'(1);

  for (gi = 0; gi < NSRC; gi++) begin : g_entry
    assign arm_vec[gi]   = a_first & (a_source == SOURCE_BITS'(gi));
    assign ret_vec[gi]   = retire & (ret_src == SOURCE_BITS'(gi));
    // Arming wins over retiring so a same-cycle retire+re-arm stays busy.
    assign busy_next[gi] = arm_vec[gi] | (busy_reg[gi] & ~ret_vec[gi]);
  end

`ifdef TL_MONITOR_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT_CYCLES);

  logic [TCNT_W-1:0] tcnt_reg [NSRC];
  logic [NSRC-1:0]   tdone_reg;
  logic [NSRC-1:0]   tout_hit;

  for (gi = 0; gi < NSRC; gi++) begin : g_tout_hit
    assign tout_hit[gi] = busy_reg[gi] & (tcnt_reg[gi] == TCNT_MAX) & ~tdone_reg[gi];
  end

  // Per-source age counters: restart on arm, saturate, report once per transaction.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < NSRC; s++) tcnt_reg[s] <= '0;
      tdone_reg <= '0;
    end else begin
      for (int s = 0; s < NSRC; s++) begin
        if (arm_vec[s]) begin
          tcnt_reg[s]  <= '0;
          tdone_reg[s] <= 1'b0;
        end else begin
          if (busy_reg[s] && (tcnt_reg[s] != TCNT_MAX)) tcnt_reg[s] <= tcnt_reg[s] + TCNT_W'(1);
          if (tout_hit[s]) tdone_reg[s] <= 1'b1;
        end
      end
    end
  end

  // Lowest-numbered timed-out source is the one reported.
  always_comb begin
    tout_any = |tout_hit;
    tout_src = '0;
    for (int s = NSRC - 1; s >= 0; s--) begin
      if (tout_hit[s]) tout_src = SOURCE_BITS'(s);
    end
  end
`else
  assign tout_any = 1'b0;
  assign tout_src = '0;
`endif

  // Violation detection for this cycle's fires.
  always_comb begin
    viol    = '0;
    viol[1] = a_first & busy_reg[a_source] & ~(retire & (ret_src == a_source));
    viol[2] = d_first & ~busy_reg[d_source];
    viol[3] = d_first & busy_reg[d_source] & (d_opcode != {2'b00, exp_op_reg[d_source]});
    viol[4] = d_first & busy_reg[d_source] & (d_size != lsize_reg[d_source]);
    viol[5] = a_mid & ((a_opcode != a_op_reg) | (a_size != a_size_reg) |
                       (a_source != a_src_reg) | (a_address != a_addr_reg));
    viol[6] = d_mid & ((d_opcode != d_op_reg) | (d_size != d_size_reg) | (d_source != d_src_reg));
    viol[7] = tout_any;
    viol[8] = a_first & ~((a_opcode == 3'd0) | (a_opcode == 3'd1) | (a_opcode == 3'd4));
    viol[9] = a_first & ((a_address & align_mask) != '0);
  end

  // Pick the lowest active code and the source it refers to.
  always_comb begin
    code_next = '0;
    src_next  = '0;
    for (int c = 9; c >= 1; c--) begin
      if (viol[c]) begin
        code_next = 4'(c);
        if (c == 7) src_next = tout_src;
        else if ((c == 2) || (c == 3) || (c == 4) || (c == 6)) src_next = d_source;
        else src_next = a_source;
      end
    end
  end

  // Population count of the post-update busy bits.
  always_comb begin
    count_next = '0;
    for (int s = 0; s < NSRC; s++) count_next = count_next + {{SOURCE_BITS{1'b0}}, busy_next[s]};
  end

  // Burst beat counters and first-beat field capture for both channels.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_rem_reg    <= '0;
      a_op_reg     <= '0;
      a_size_reg   <= '0;
      a_src_reg    <= '0;
      a_addr_reg   <= '0;
      d_rem_reg    <= '0;
      d_op_reg     <= '0;
      d_size_reg   <= '0;
      d_src_reg    <= '0;
      d_req_ok_reg <= 1'b0;
    end else begin
      if (a_first) begin
        a_rem_reg  <= a_beats - BCNT_W'(1);
        a_op_reg   <= a_opcode;
        a_size_reg <= a_size;
        a_src_reg  <= a_source;
        a_addr_reg <= a_address;
      end else if (a_mid) begin
        a_rem_reg  <= a_rem_reg - BCNT_W'(1);
      end
      if (d_first) begin
        d_rem_reg    <= d_beats - BCNT_W'(1);
        d_op_reg     <= d_opcode;
        d_size_reg   <= d_size;
        d_src_reg    <= d_source;
        d_req_ok_reg <= busy_reg[d_source];
      end else if (d_mid) begin
        d_rem_reg    <= d_rem_reg - BCNT_W'(1);
      end
    end
  end

  // Per-source table: busy bit plus the expectations captured at arm time.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_reg   <= '0;
      exp_op_reg <= '0;
      for (int s = 0; s < NSRC; s++) lsize_reg[s] <= '0;
    end else begin
      busy_reg <= busy_next;
      for (int s = 0; s < NSRC; s++) begin
        if (arm_vec[s]) begin
          exp_op_reg[s] <= (a_opcode == 3'd4);
          lsize_reg[s]  <= a_size;
        end
      end
    end
  end

  // Registered error report, sticky flags and inflight count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_valid_reg  <= 1'b0;
      err_code_reg   <= '0;
      err_source_reg <= '0;
      err_flags_reg  <= '0;
      inflight_reg   <= '0;
    end else begin
      err_valid_reg  <= |viol;
      err_code_reg   <= code_next;
      err_source_reg <= src_next;
      err_flags_reg  <= err_flags_reg | viol;
      inflight_reg   <= count_next;
    end
  end

  assign err_valid      = err_valid_reg;
  assign err_code       = err_code_reg;
  assign err_source     = err_source_reg;
  assign err_flags      = err_flags_reg;
  assign inflight_count = inflight_reg;

endmodule

// File: tb/tb_tl_inflight_monitor.sv
// tb_tl_inflight_monitor: directed scenarios plus randomized traffic checked
// against a transaction-level reference model of the monitor's rules.
module tb_tl_inflight_monitor;
  localparam int SB   = 3;
  localparam int AB   = 31;
  localparam int ZB   = 3;
  localparam int BL   = 2;
  localparam int TO   = 16;
  localparam int NSRC = 1 << SB;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          a_valid, a_ready, d_valid, d_ready;
  logic [2:0]    a_opcode, d_opcode;
  logic [ZB-1:0] a_size, d_size;
  logic [SB-1:0] a_source, d_source;
  logic [AB-1:0] a_address;
  logic          err_valid;
  logic [3:0]    err_code;
  logic [SB-1:0] err_source;
  logic [9:0]    err_flags;
  logic [SB:0]   inflight_count;

  tl_inflight_monitor #(
    .SOURCE_BITS(SB), .ADDR_BITS(AB), .SIZE_BITS(ZB), .BEAT_LOG2(BL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
    .a_source(a_source), .a_address(a_address),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source),
    .err_valid(err_valid), .err_code(err_code), .err_source(err_source),
    .err_flags(err_flags), .inflight_count(inflight_count)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit     m_busy  [NSRC];
  int     m_expop [NSRC];
  int     m_size  [NSRC];
  int     m_age   [NSRC];
  bit     m_rep   [NSRC];
  int     a_left, a_f_op, a_f_size, a_f_src;
  longint a_f_addr;
  int     d_left, d_f_op, d_f_size, d_f_src;
  bit     d_f_known;
  bit     x_valid;
  int     x_code, x_src, x_inflight;
  bit [9:0] x_flags;

  function automatic int nbeats(input int sz);
    return (sz <= BL) ? 1 : (1 << (sz - BL));
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NSRC; s++) begin
      m_busy[s] = 0; m_expop[s] = 0; m_size[s] = 0; m_age[s] = 0; m_rep[s] = 0;
    end
    a_left = 0; a_f_op = 0; a_f_size = 0; a_f_src = 0; a_f_addr = 0;
    d_left = 0; d_f_op = 0; d_f_size = 0; d_f_src = 0; d_f_known = 0;
    x_valid = 0; x_code = 0; x_src = 0; x_inflight = 0; x_flags = '0;
  endtask

  // Apply one clock edge worth of rules to the model using current inputs.
  task automatic model_cycle();
    bit viol [10];
    int vsrc [10];
    bit af, df, a_first, d_first, d_last, ret_ok;
    int ret_src, aop, asz, as, dop, dsz, ds, cnt;
    longint aaddr;
    for (int c = 0; c < 10; c++) begin viol[c] = 0; vsrc[c] = 0; end
    af = a_valid && a_ready;
    df = d_valid && d_ready;
    aop = int'(a_opcode); asz = int'(a_size); as = int'(a_source); aaddr = longint'(a_address);
    dop = int'(d_opcode); dsz = int'(d_size); ds = int'(d_source);
    a_first = af && (a_left == 0);
    d_first = df && (d_left == 0);
    if (d_first) begin
      d_last  = ((dop == 1) ? nbeats(dsz) : 1) == 1;
      ret_src = ds;
      ret_ok  = m_busy[ds];
    end else begin
      d_last  = df && (d_left == 1);
      ret_src = d_f_src;
      ret_ok  = d_f_known;
    end
    if (a_first) begin
      if (m_busy[as] && !(d_last && ret_ok && ret_src == as)) begin viol[1] = 1; vsrc[1] = as; end
      if (!(aop inside {0, 1, 4})) begin viol[8] = 1; vsrc[8] = as; end
      if ((aaddr % (longint'(1) << asz)) != 0) begin viol[9] = 1; vsrc[9] = as; end
    end else if (af) begin
      if (aop != a_f_op || asz != a_f_size || as != a_f_src || aaddr != a_f_addr) begin
        viol[5] = 1; vsrc[5] = as;
      end
    end
    if (d_first) begin
      if (!m_busy[ds]) begin viol[2] = 1; vsrc[2] = ds; end
      else begin
        if (dop != m_expop[ds]) begin viol[3] = 1; vsrc[3] = ds; end
        if (dsz != m_size[ds])  begin viol[4] = 1; vsrc[4] = ds; end
      end
    end else if (df) begin
      if (dop != d_f_op || dsz != d_f_size || ds != d_f_src) begin viol[6] = 1; vsrc[6] = ds; end
    end
`ifdef TL_MONITOR_TIMEOUT_EN
    for (int s = NSRC - 1; s >= 0; s--) begin
      if (m_busy[s] && m_age[s] >= TO && !m_rep[s]) begin
        viol[7] = 1; vsrc[7] = s; m_rep[s] = 1;
      end
    end
`endif
    // burst bookkeeping
    if (a_first) begin
      a_left = ((aop <= 1) ? nbeats(asz) : 1) - 1;
      a_f_op = aop; a_f_size = asz; a_f_src = as; a_f_addr = aaddr;
    end else if (af) a_left--;
    if (d_first) begin
      d_left = ((dop == 1) ? nbeats(dsz) : 1) - 1;
      d_f_op = dop; d_f_size = dsz; d_f_src = ds; d_f_known = m_busy[ds];
    end else if (df) d_left--;
    // outstanding table
    for (int s = 0; s < NSRC; s++) if (m_busy[s] && m_age[s] < TO) m_age[s]++;
    if (d_last && ret_ok) m_busy[ret_src] = 0;
    if (a_first) begin
      m_busy[as] = 1; m_expop[as] = (aop == 4) ? 1 : 0; m_size[as] = asz;
      m_age[as] = 0; m_rep[as] = 0;
    end
    // expected report
    x_valid = 0;
    for (int c = 9; c >= 1; c--) begin
      if (viol[c]) begin
        x_valid = 1; x_code = c; x_src = vsrc[c]; x_flags[c] = 1'b1;
      end
    end
    cnt = 0;
    for (int s = 0; s < NSRC; s++) cnt += m_busy[s] ? 1 : 0;
    x_inflight = cnt;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    a_valid = 0; a_ready = 0; a_opcode = '0; a_size = '0; a_source = '0; a_address = '0;
    d_valid = 0; d_ready = 0; d_opcode = '0; d_size = '0; d_source = '0;
  endtask

  task automatic drive_a(input int op, input int sz, input int src, input int addr);
    a_valid = 1; a_ready = 1; a_opcode = 3'(op); a_size = ZB'(sz); a_source = SB'(src); a_address = AB'(addr);
  endtask

  task automatic drive_d(input int op, input int sz, input int src);
    d_valid = 1; d_ready = 1; d_opcode = 3'(op); d_size = ZB'(sz); d_source = SB'(src);
  endtask

  task automatic step(input string tag);
    model_cycle();
    @(posedge clock);
    #1;
    check({tag, ".err_valid"}, 64'(err_valid), 64'(x_valid));
    if (x_valid) begin
      check({tag, ".err_code"}, 64'(err_code), 64'(x_code));
      check({tag, ".err_source"}, 64'(err_source), 64'(x_src));
    end
    check({tag, ".err_flags"}, 64'(err_flags), 64'(x_flags));
    check({tag, ".inflight"}, 64'(inflight_count), 64'(x_inflight));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".err_valid"}, 64'(err_valid), 64'd0);
    check({tag, ".err_code"}, 64'(err_code), 64'd0);
    check({tag, ".err_source"}, 64'(err_source), 64'd0);
    check({tag, ".err_flags"}, 64'(err_flags), 64'd0);
    check({tag, ".inflight"}, 64'(inflight_count), 64'd0);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic do_reset(input string tag);
    idle();
    #2 reset_n = 0;
    model_reset();
    #1 check_zero(tag);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1;
  endtask

  task automatic rand_drive();
    int busyq[$];
    int s, pick;
    a_ready = ($urandom_range(0, 3) != 0);
    d_ready = ($urandom_range(0, 3) != 0);
    a_valid = ($urandom_range(0, 2) == 0);
    d_valid = ($urandom_range(0, 2) == 0);
    if (a_left > 0 && $urandom_range(0, 9) != 0) begin
      a_opcode = 3'(a_f_op); a_size = ZB'(a_f_size); a_source = SB'(a_f_src); a_address = AB'(a_f_addr);
    end else begin
      pick = $urandom_range(0, 9);
      if (pick < 4) a_opcode = 3'd4;
      else if (pick < 6) a_opcode = 3'd0;
      else if (pick < 8) a_opcode = 3'd1;
      else a_opcode = 3'($urandom_range(0, 7));
      a_size    = ZB'($urandom_range(0, 4));
      a_source  = SB'($urandom_range(0, NSRC - 1));
      a_address = AB'($urandom());
      if ($urandom_range(0, 9) != 0) a_address = a_address & ~((AB'(1) << a_size) - AB'(1));
    end
    for (int i = 0; i < NSRC; i++) if (m_busy[i]) busyq.push_back(i);
    if (d_left > 0 && $urandom_range(0, 9) != 0) begin
      d_opcode = 3'(d_f_op); d_size = ZB'(d_f_size); d_source = SB'(d_f_src);
    end else begin
      if (busyq.size() > 0 && $urandom_range(0, 4) != 0) s = busyq[$urandom_range(0, busyq.size() - 1)];
      else s = $urandom_range(0, NSRC - 1);
      d_source = SB'(s);
      d_opcode = 3'(m_expop[s]);
      if ($urandom_range(0, 9) == 0) d_opcode = 3'($urandom_range(0, 7));
      d_size = ZB'(m_size[s]);
      if ($urandom_range(0, 9) == 0) d_size = ZB'($urandom_range(0, 4));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits, first;
    bit af, df;
    idle();
    model_reset();
    do_reset("reset");

    // Get src3, AccessAckData five cycles later.
    drive_a(4, 2, 3, 0); step("t1_get"); idle();
    $display("txn t1: Get src=3 size=2 inflight=%0d", inflight_count);
    check("t1_inflight_up", 64'(inflight_count), 64'd1);
    repeat (4) step("t1_wait");
    drive_d(1, 2, 3); step("t1_ack"); idle();
    $display("txn t1: AccessAckData src=3 err_valid=%0b inflight=%0d", err_valid, inflight_count);
    check("t1_no_err", 64'(err_valid), 64'd0);
    check("t1_inflight_down", 64'(inflight_count), 64'd0);

    // Second Get on an outstanding source.
    drive_a(4, 2, 3, 0); step("t2_get1");
    drive_a(4, 2, 3, 0); step("t2_get2"); idle();
    $display("txn t2: repeated Get src=3 err_code=%0d src=%0d", err_code, err_source);
    check("t2_valid", 64'(err_valid), 64'd1);
    check("t2_code", 64'(err_code), 64'd1);
    check("t2_src", 64'(err_source), 64'd3);
    check("t2_flag1", 64'(err_flags[1]), 64'd1);

    // PutFull 4 beats with the address changing on beat 3.
    do_reset("t3_rst");
    drive_a(0, 4, 4, 'h40); step("t3_b1");
    check("t3_inflight", 64'(inflight_count), 64'd1);
    step("t3_b2");
    drive_a(0, 4, 4, 'h44); step("t3_b3");
    $display("txn t3: PutFull beat3 addr change err_code=%0d", err_code);
    check("t3_code", 64'(err_code), 64'd5);
    check("t3_src", 64'(err_source), 64'd4);
    drive_a(0, 4, 4, 'h40); step("t3_b4"); idle();
    check("t3_b4_clean", 64'(err_valid), 64'd0);
    drive_d(0, 4, 4); step("t3_ack"); idle();
    $display("txn t3: AccessAck src=4 err_valid=%0b inflight=%0d", err_valid, inflight_count);
    check("t3_ack_clean", 64'(err_valid), 64'd0);
    check("t3_retired", 64'(inflight_count), 64'd0);

    // D on idle source together with an illegal A opcode.
    do_reset("t4_rst");
    drive_d(0, 0, 5); drive_a(2, 0, 1, 0); step("t4"); idle();
    $display("txn t4: D idle src=5 + A opcode 2 err_code=%0d flags=%b", err_code, err_flags);
    check("t4_code", 64'(err_code), 64'd2);
    check("t4_src", 64'(err_source), 64'd5);
    check("t4_flag2", 64'(err_flags[2]), 64'd1);
    check("t4_flag8", 64'(err_flags[8]), 64'd1);

    // Same-cycle retire and re-arm on source 0.
    do_reset("t5_rst");
    drive_a(4, 2, 0, 0); step("t5_get");
    drive_d(1, 2, 0); drive_a(4, 2, 0, 0); step("t5_swap"); idle();
    $display("txn t5: retire+rearm src=0 err_valid=%0b inflight=%0d", err_valid, inflight_count);
    check("t5_no_err", 64'(err_valid), 64'd0);
    check("t5_inflight", 64'(inflight_count), 64'd1);

    // Asynchronous reset mid-burst discards everything.
    do_reset("t6_rst");
    drive_a(0, 4, 6, 'h80); step("t6_b1");
    drive_a(0, 4, 6, 'h90); step("t6_b2"); idle();
    check("t6_pre_flag5", 64'(err_flags[5]), 64'd1);
    do_reset("t6_mid");
    drive_a(4, 2, 6, 0); step("t6_after"); idle();
    $display("txn t6: Get after mid-burst reset err_valid=%0b", err_valid);
    check("t6_burst_dropped", 64'(err_valid), 64'd0);

`ifdef TL_MONITOR_TIMEOUT_EN
    // Get with no response: one timeout report TIMEOUT_CYCLES+1 edges later.
    do_reset("t7_rst");
    drive_a(4, 2, 2, 0); step("t7_get"); idle();
    hits = 0; first = 0;
    for (int i = 1; i <= 40; i++) begin
      step("t7_wait");
      if (err_valid) begin
        hits++;
        if (first == 0) first = i;
        check("t7_code", 64'(err_code), 64'd7);
        check("t7_src", 64'(err_source), 64'd2);
      end
    end
    $display("txn t7: timeout src=2 first=%0d hits=%0d", first, hits);
    check("t7_when", 64'(first), 64'(TO + 1));
    check("t7_once", 64'(hits), 64'd1);
    do_reset("t7_rst2");
    drive_a(4, 2, 2, 0); step("t7_get2"); idle();
    repeat (8) step("t7_wait2");
    do_reset("t7_mid");
`endif

    // Randomized traffic against the model, with one reset in the middle.
    do_reset("rand_rst");
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc == 700) do_reset("rand_mid");
      rand_drive();
      af = a_valid && a_ready;
      df = d_valid && d_ready;
      step("rand");
      if (af || df)
        $display("txn rand %0d: a_fire=%0b d_fire=%0b err_valid=%0b code=%0d inflight=%0d",
                 cyc, af, df, err_valid, err_code, inflight_count);
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
